dma_ring_sched: RTL

- Scheduler that sequences a dma_writer to capture a continuous stream into a circular buffer in memory.
- Splits the ring into segments and issues one dma_writer transfer per segment, wrapping at the ring end.
- Reports write pointer, wrap, segment count and errors to the register file, and raises a per-segment interrupt pulse.
- Sits between the control/status register block and dma_writer's configuration port.

---
 rtl/dma_ring_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dma_ring_sched.sv
// Ring-buffer capture scheduler: carves a circular memory region into segments
// and hands them one at a time to dma_writer, wrapping at the ring end.
module dma_ring_sched #(
  parameter int AddrBits   = 32,
  parameter int LengthBits = 16,
  parameter int RingBits   = 24,
  parameter int DataBits   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  input  logic                  ctrl_oneshot,
  input  logic [AddrBits-1:0]   ctrl_base,
  input  logic [RingBits-1:0]   ctrl_ring_words,
  input  logic [LengthBits-1:0] ctrl_seg_words,
  input  logic [4:0]            ctrl_burst,
  output logic                  stat_busy,
  output logic [RingBits-1:0]   stat_wr_ptr,
  output logic                  stat_wrapped,
  output logic [31:0]           stat_seg_count,
  output logic [1:0]            stat_err,
  output logic                  stat_bad_cfg,
  output logic                  irq_seg,
  output logic [AddrBits-1:0]   dma_cfg_dest,
  output logic [LengthBits-1:0] dma_cfg_len,
  output logic [4:0]            dma_cfg_burst,
  output logic                  dma_cfg_valid,
  input  logic                  dma_cfg_busy,
  input  logic                  dma_cfg_done,
  input  logic [1:0]            dma_cfg_err
);
  localparam int BytesPerWord = DataBits / 8;
  localparam int WordShift    = $clog2(BytesPerWord);
  localparam int CmpBits      = (RingBits > LengthBits) ? RingBits : LengthBits;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CALC    = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_ADVANCE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [AddrBits-1:0]   base_q;
  logic [RingBits-1:0]   ring_q;
  logic [LengthBits-1:0] seg_q;
  logic [4:0]            burst_q;
  logic                  oneshot_q;
  logic                  stop_pending_q;
  logic [RingBits-1:0]   offset_q;
  logic                  wrapped_q;
  logic                  bad_cfg_q;
  logic                  irq_q;
  logic [31:0]           seg_count_q;
  logic [1:0]            err_q;
  logic [AddrBits-1:0]   dest_q;
  logic [LengthBits-1:0] len_q;

  logic                  cfg_ok;
  logic                  stop_now;
  logic                  wrap_now;
  logic [RingBits-1:0]   remaining;
  logic [RingBits-1:0]   offset_sum;
  logic [LengthBits-1:0] len_calc;
  logic [AddrBits-1:0]   dest_calc;

  // A stop seen this cycle counts as pending, so start+stop together issues nothing.
  always_comb begin
    cfg_ok     = (ctrl_ring_words != '0) && (ctrl_seg_words != '0);
    stop_now   = stop_pending_q | ctrl_stop;
    remaining  = ring_q - offset_q;
    len_calc   = (CmpBits'(seg_q) <= CmpBits'(remaining)) ? seg_q : LengthBits'(remaining);
    dest_calc  = base_q + (AddrBits'(offset_q) << WordShift);
    offset_sum = offset_q + RingBits'(len_q);
    wrap_now   = (offset_sum == ring_q);
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ctrl_start && cfg_ok) state_d = ST_CALC;
      ST_CALC:    state_d = stop_now ? ST_IDLE : ST_ISSUE;
      ST_ISSUE: begin
        if (stop_now)          state_d = ST_IDLE;
        else if (!dma_cfg_busy) state_d = ST_WAIT;
      end
      ST_WAIT:    if (dma_cfg_done) state_d = ST_ADVANCE;
      ST_ADVANCE: state_d = (stop_now || (oneshot_q && wrap_now)) ? ST_IDLE : ST_CALC;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      base_q         <= '0;
      ring_q         <= '0;
      seg_q          <= '0;
      burst_q        <= '0;
      oneshot_q      <= 1'b0;
      stop_pending_q <= 1'b0;
      offset_q       <= '0;
      wrapped_q      <= 1'b0;
      bad_cfg_q      <= 1'b0;
      irq_q          <= 1'b0;
      seg_count_q    <= '0;
      err_q          <= '0;
      dest_q         <= '0;
      len_q          <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= 1'b0;

      if (state_d == ST_IDLE)  stop_pending_q <= 1'b0;
      else if (ctrl_stop)      stop_pending_q <= 1'b1;

      if ((state_q != ST_IDLE) && (dma_cfg_err != '0) && (err_q == '0)) err_q <= dma_cfg_err;

      case (state_q)
        ST_IDLE: begin
          if (ctrl_start && !cfg_ok) begin
            bad_cfg_q <= 1'b1;
          end else if (ctrl_start) begin
            base_q      <= (ctrl_base >> WordShift) << WordShift;
            ring_q      <= ctrl_ring_words;
            seg_q       <= ctrl_seg_words;
            burst_q     <= ctrl_burst;
            oneshot_q   <= ctrl_oneshot;
            wrapped_q   <= 1'b0;
            err_q       <= '0;
            bad_cfg_q   <= 1'b0;
            seg_count_q <= '0;
            offset_q    <= '0;
          end
        end
        ST_CALC: begin
          dest_q <= dest_calc;
          len_q  <= len_calc;
        end
        ST_ADVANCE: begin
          offset_q    <= wrap_now ? '0 : offset_sum;
          if (wrap_now) wrapped_q <= 1'b1;
          seg_count_q <= seg_count_q + 32'd1;
          irq_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stat_busy      = (state_q != ST_IDLE);
  assign stat_wr_ptr    = offset_q;
  assign stat_wrapped   = wrapped_q;
  assign stat_seg_count = seg_count_q;
  assign stat_err       = err_q;
  assign stat_bad_cfg   = bad_cfg_q;
  assign irq_seg        = irq_q;
  assign dma_cfg_dest   = dest_q;
  assign dma_cfg_len    = len_q;
  assign dma_cfg_burst  = burst_q;
  // Valid is combinational so it lands on the first cycle dma_writer reports idle.
  assign dma_cfg_valid  = (state_q == ST_ISSUE) && !dma_cfg_busy && !stop_now;

endmodule
